// File: rtl/song_recorder.sv
// song_recorder: turns live note/beat events into note, WAIT and end-marker command words for song RAM.
// Build option: SKIP_LEAD_SILENCE_EN ignores beats until the first accepted note of a take.
module song_recorder #(
    parameter int SONG_W   = 2,
    parameter int INDEX_W  = 7,
    parameter int MAX_WAIT = 63
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      record,
    input  logic [SONG_W-1:0]         song,
    input  logic                      beat,
    input  logic                      note_valid,
    input  logic [5:0]                note,
    input  logic [5:0]                duration,
    output logic                      wr_en,
    output logic [SONG_W+INDEX_W-1:0] wr_addr,
    output logic [15:0]               wr_data,
    output logic                      recording,
    output logic                      song_done,
    output logic [INDEX_W-1:0]        length,
    output logic                      full,
    output logic                      dropped
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REC   = 3'd1,
        S_NOTE  = 3'd2,
        S_FLUSH = 3'd3,
        S_END   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [INDEX_W-1:0] LAST_IDX   = {INDEX_W{1'b1}};
    localparam logic [5:0]         MAX_WAIT_C = 6'(MAX_WAIT);

    function automatic logic [15:0] note_word(input logic [5:0] n, input logic [5:0] d);
        return {1'b0, n, d, 3'b000};
    endfunction

    function automatic logic [15:0] wait_word(input logic [5:0] b);
        return {1'b1, b, 6'd0, 3'b000};
    endfunction

    state_t              state_r, state_s;
    logic [SONG_W-1:0]   slot_r, slot_s;
    logic [INDEX_W-1:0]  index_r, index_s, idx_inc_s;
    logic [5:0]          beat_cnt_r, beat_cnt_s, cnt_eff_s;
    logic [11:0]         pend_r, pend_s;
    logic                full_s, dropped_s;
    logic                wr_en_s;
    logic [15:0]         wr_data_s;
    logic                beat_eff_s, note_real_s, overflow_s, hit_last_s;

`ifdef SKIP_LEAD_SILENCE_EN
    logic                seen_r, seen_s;
    assign beat_eff_s = beat && seen_r;
`else
    assign beat_eff_s = beat;
`endif

    // An all-zero note event is treated as no event at all
    assign note_real_s = note_valid && !((note == 6'd0) && (duration == 6'd0));
    assign overflow_s  = beat_eff_s && (beat_cnt_r == MAX_WAIT_C);
    assign cnt_eff_s   = beat_cnt_r + {5'd0, beat_eff_s};
    assign idx_inc_s   = index_r + INDEX_W'(1);
    assign hit_last_s  = (idx_inc_s == LAST_IDX);

    // Next-state, next-entry and write-command logic
    always_comb begin
        state_s    = state_r;
        slot_s     = slot_r;
        index_s    = index_r;
        beat_cnt_s = beat_cnt_r;
        pend_s     = pend_r;
        full_s     = full;
        dropped_s  = dropped;
        wr_en_s    = 1'b0;
        wr_data_s  = 16'h0000;
`ifdef SKIP_LEAD_SILENCE_EN
        seen_s     = seen_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (record) begin
                    slot_s     = song;
                    index_s    = '0;
                    beat_cnt_s = 6'd0;
                    full_s     = 1'b0;
                    dropped_s  = 1'b0;
`ifdef SKIP_LEAD_SILENCE_EN
                    seen_s     = 1'b0;
`endif
                    state_s    = S_REC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REC: begin
                if (overflow_s) begin
                    // Full-size WAIT goes out first; the overflowing beat starts the next count
                    wr_en_s    = 1'b1;
                    wr_data_s  = wait_word(MAX_WAIT_C);
                    index_s    = idx_inc_s;
                    beat_cnt_s = 6'd1;
                    if (hit_last_s) begin
                        full_s    = 1'b1;
                        dropped_s = dropped | note_real_s;
                        state_s   = S_END;
                    end else if (!record) begin
                        dropped_s = dropped | note_real_s;
                        state_s   = S_FLUSH;
                    end else if (note_real_s) begin
                        pend_s  = {note, duration};
                        state_s = S_NOTE;
`ifdef SKIP_LEAD_SILENCE_EN
                        seen_s  = 1'b1;
`endif
                    end else begin
                        state_s = S_REC;
                    end
                end else if (!record) begin
                    beat_cnt_s = cnt_eff_s;
                    dropped_s  = dropped | note_real_s;
                    state_s    = S_FLUSH;
                end else if (note_real_s) begin
                    wr_en_s = 1'b1;
                    index_s = idx_inc_s;
`ifdef SKIP_LEAD_SILENCE_EN
                    seen_s  = 1'b1;
`endif
                    if (cnt_eff_s == 6'd0) begin
                        wr_data_s = note_word(note, duration);
                        if (hit_last_s) begin
                            full_s  = 1'b1;
                            state_s = S_END;
                        end else begin
                            state_s = S_REC;
                        end
                    end else begin
                        wr_data_s  = wait_word(cnt_eff_s);
                        beat_cnt_s = 6'd0;
                        if (hit_last_s) begin
                            full_s    = 1'b1;
                            dropped_s = 1'b1;
                            state_s   = S_END;
                        end else begin
                            pend_s  = {note, duration};
                            state_s = S_NOTE;
                        end
                    end
                end else begin
                    beat_cnt_s = cnt_eff_s;
                end
            end
            S_NOTE: begin
                wr_en_s    = 1'b1;
                wr_data_s  = note_word(pend_r[11:6], pend_r[5:0]);
                index_s    = idx_inc_s;
                beat_cnt_s = cnt_eff_s;
                dropped_s  = dropped | note_real_s;
                if (hit_last_s) begin
                    full_s  = 1'b1;
                    state_s = S_END;
                end else begin
                    state_s = S_REC;
                end
            end
            S_FLUSH: begin
                if (beat_cnt_r != 6'd0) begin
                    wr_en_s   = 1'b1;
                    wr_data_s = wait_word(beat_cnt_r);
                    index_s   = idx_inc_s;
                    full_s    = hit_last_s;
                end else begin
                    wr_en_s = 1'b0;
                end
                beat_cnt_s = 6'd0;
                state_s    = S_END;
            end
            S_END: begin
                // End marker sits at the current index and is not counted in length
                wr_en_s   = 1'b1;
                wr_data_s = 16'h0000;
                state_s   = S_DONE;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered RAM-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            slot_r     <= '0;
            index_r    <= '0;
            beat_cnt_r <= 6'd0;
            pend_r     <= 12'd0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 16'h0000;
            recording  <= 1'b0;
            song_done  <= 1'b0;
            length     <= '0;
            full       <= 1'b0;
            dropped    <= 1'b0;
`ifdef SKIP_LEAD_SILENCE_EN
            seen_r     <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            slot_r     <= slot_s;
            index_r    <= index_s;
            beat_cnt_r <= beat_cnt_s;
            pend_r     <= pend_s;
            wr_en      <= wr_en_s;
            wr_addr    <= {slot_r, index_r};
            wr_data    <= wr_data_s;
            recording  <= (state_s == S_REC) || (state_s == S_NOTE) ||
                          (state_s == S_FLUSH) || (state_s == S_END);
            song_done  <= (state_s == S_DONE);
            length     <= index_s;
            full       <= full_s;
            dropped    <= dropped_s;
`ifdef SKIP_LEAD_SILENCE_EN
            seen_r     <= seen_s;
`endif
        end
    end
endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder (default build): vector table plus hand-written overflow, full and reset sequences.
module tb_song_recorder;
    logic       clk = 1'b0;
    logic       reset;
    logic       record;
    logic [1:0] song;
    logic       beat;
    logic       note_valid;
    logic [5:0] note;
    logic [5:0] duration;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [15:0] wr_data;
    logic       recording;
    logic       song_done;
    logic [6:0] length;
    logic       full;
    logic       dropped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    song_recorder dut (
        .clk(clk), .reset(reset), .record(record), .song(song), .beat(beat),
        .note_valid(note_valid), .note(note), .duration(duration),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .recording(recording),
        .song_done(song_done), .length(length), .full(full), .dropped(dropped)
    );

    typedef struct {
        logic rec; logic [1:0] sng; logic bt; logic nv; logic [5:0] nt; logic [5:0] du;
        logic en; logic [8:0] addr; logic [15:0] data;
        logic recg; logic done; logic [6:0] len; logic fl; logic drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rec, input logic [1:0] sng, input logic bt, input logic nv,
                                input logic [5:0] nt, input logic [5:0] du, input logic en,
                                input logic [8:0] addr, input logic [15:0] data, input logic recg,
                                input logic done, input logic [6:0] len, input logic fl, input logic drop);
        vec_t v;
        v.rec = rec; v.sng = sng; v.bt = bt; v.nv = nv; v.nt = nt; v.du = du;
        v.en = en; v.addr = addr; v.data = data; v.recg = recg; v.done = done;
        v.len = len; v.fl = fl; v.drop = drop;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] s, input logic b, input logic nv,
                        input logic [5:0] n, input logic [5:0] d);
        record = r; song = s; beat = b; note_valid = nv; note = n; duration = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string nm, input logic [8:0] addr, input logic [15:0] data);
        check({nm, " wr_en"}, 32'(wr_en), 32'd1);
        check({nm, " wr_addr"}, 32'(wr_addr), 32'(addr));
        check({nm, " wr_data"}, 32'(wr_data), 32'(data));
    endtask

    initial begin
        vec_t v;
        logic [5:0] nt;
        logic [5:0] du;
        reset = 1'b1;
        record = 1'b0; song = 2'd0; beat = 1'b0; note_valid = 1'b0; note = 6'd0; duration = 6'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst wr_addr", 32'(wr_addr), 32'd0);
        check("rst wr_data", 32'(wr_data), 32'd0);
        check("rst recording", 32'(recording), 32'd0);
        check("rst song_done", 32'(song_done), 32'd0);
        check("rst length", 32'(length), 32'd0);
        check("rst full", 32'(full), 32'd0);
        check("rst dropped", 32'(dropped), 32'd0);
        reset = 1'b0;

        // slot 1: zero note ignored, one note, finish take
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 6'd20, 6'd8, 1'b1, 9'h080, 16'h2840, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 6'd0,  6'd0, 1'b1, 9'h081, 16'h0000, 1'b0, 1'b1, 7'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0));
        // slot 0: 3 beats then note; one beat plus beat on record fall gets flushed
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 1'b1, 6'd5,  6'd4, 1'b1, 9'h000, 16'h8600, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0, 1'b1, 9'h001, 16'h0A20, 1'b1, 1'b0, 7'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0, 1'b1, 9'h002, 16'h8400, 1'b1, 1'b0, 7'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0, 1'b1, 9'h003, 16'h0000, 1'b0, 1'b1, 7'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 7'd3, 1'b0, 1'b0));
        // slot 2: beat, beat+note, note while pending is dropped
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd2, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd2, 1'b1, 1'b1, 6'd1,  6'd1, 1'b1, 9'h100, 16'h8400, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 1'b1, 6'd2,  6'd2, 1'b1, 9'h101, 16'h0208, 1'b1, 1'b0, 7'd2, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd2, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 7'd2, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 6'd0,  6'd0, 1'b1, 9'h102, 16'h0000, 1'b0, 1'b1, 7'd2, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 7'd2, 1'b0, 1'b1));

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            step(v.rec, v.sng, v.bt, v.nv, v.nt, v.du);
            check($sformatf("vec%0d wr_en", k), 32'(wr_en), 32'(v.en));
            if (v.en) begin
                check($sformatf("vec%0d wr_addr", k), 32'(wr_addr), 32'(v.addr));
                check($sformatf("vec%0d wr_data", k), 32'(wr_data), 32'(v.data));
            end
            check($sformatf("vec%0d recording", k), 32'(recording), 32'(v.recg));
            check($sformatf("vec%0d song_done", k), 32'(song_done), 32'(v.done));
            check($sformatf("vec%0d length", k), 32'(length), 32'(v.len));
            check($sformatf("vec%0d full", k), 32'(full), 32'(v.fl));
            check($sformatf("vec%0d dropped", k), 32'(dropped), 32'(v.drop));
        end

        // slot 3: 70 beats -> WAIT(63) on the 64th beat, WAIT(7) flushed, marker
        step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
        check("ovf start recording", 32'(recording), 32'd1);
        check("ovf start dropped", 32'(dropped), 32'd0);
        for (int i = 1; i <= 70; i++) begin
            step(1'b1, 2'd3, 1'b1, 1'b0, 6'd0, 6'd0);
            if (i == 64) begin
                check_write("ovf wait63", 9'h180, 16'hFE00);
            end else begin
                check($sformatf("ovf beat%0d wr_en", i), 32'(wr_en), 32'd0);
            end
        end
        step(1'b0, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
        check("ovf fall wr_en", 32'(wr_en), 32'd0);
        step(1'b0, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
        check_write("ovf flush", 9'h181, 16'h8E00);
        step(1'b0, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
        check_write("ovf marker", 9'h182, 16'h0000);
        check("ovf song_done", 32'(song_done), 32'd1);
        check("ovf length", 32'(length), 32'd2);
        step(1'b0, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);

        // slot 0: 127 notes fill the song, marker at the last slot without record falling
        step(1'b1, 2'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        for (int i = 0; i < 127; i++) begin
            nt = 6'((i % 63) + 1);
            du = 6'(i % 64);
            step(1'b1, 2'd0, 1'b0, 1'b1, nt, du);
            check_write($sformatf("full note%0d", i), 9'(i), {1'b0, nt, du, 3'b000});
            if (i == 125) check("full early", 32'(full), 32'd0);
        end
        check("full flag", 32'(full), 32'd1);
        check("full length", 32'(length), 32'd127);
        step(1'b1, 2'd0, 1'b0, 1'b1, 6'd7, 6'd7);
        check_write("full marker", 9'h07F, 16'h0000);
        check("full song_done", 32'(song_done), 32'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 6'd9, 6'd9);
        check("full after wr_en", 32'(wr_en), 32'd0);
        check("full hold", 32'(full), 32'd1);
        check("full length hold", 32'(length), 32'd127);
        check("full dropped", 32'(dropped), 32'd0);

        // reset while a pending note waits in S_NOTE
        step(1'b1, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        step(1'b1, 2'd1, 1'b1, 1'b0, 6'd0, 6'd0);
        step(1'b1, 2'd1, 1'b0, 1'b1, 6'd3, 6'd3);
        check_write("rstmid wait1", 9'h080, 16'h8200);
        reset = 1'b1;
        step(1'b1, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        check("rstmid wr_en", 32'(wr_en), 32'd0);
        check("rstmid wr_addr", 32'(wr_addr), 32'd0);
        check("rstmid wr_data", 32'(wr_data), 32'd0);
        check("rstmid recording", 32'(recording), 32'd0);
        check("rstmid length", 32'(length), 32'd0);
        check("rstmid full", 32'(full), 32'd0);
        reset = 1'b0;
        step(1'b1, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        check("restart recording", 32'(recording), 32'd1);
        step(1'b1, 2'd1, 1'b0, 1'b1, 6'd4, 6'd4);
        check_write("restart note", 9'h080, 16'h0820);
        step(1'b0, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        step(1'b0, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        step(1'b0, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        check_write("restart marker", 9'h081, 16'h0000);
        check("restart length", 32'(length), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Captures live note events into song RAM in the same 16-bit command format that song_reader plays back: the writer for the reader's ROM/RAM stream.
- Converts beat gaps between notes into WAIT commands, appends the end marker, and signals completion.
- Sits between the note input source (keyboard/button decoder plus beat generator) and the write port of the song RAM.

Parameters:
- SONG_W, 2, song slot select width; RAM address = {slot, index}.
- INDEX_W, 7, entry index width; 2^INDEX_W entries per song, last slot reserved for the end marker.
- MAX_WAIT, 63, largest WAIT value per entry; must fit in 6 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- record  in  1  level; high = take in progress, falling = finish take
- song  in  SONG_W  target slot; latched on take start
- beat  in  1  one-cycle beat strobe
- note_valid  in  1  one-cycle note event strobe
- note  in  6  note value, sampled with note_valid
- duration  in  6  note duration, sampled with note_valid
- wr_en  out  1  RAM write strobe
- wr_addr  out  SONG_W+INDEX_W  {latched slot, index}
- wr_data  out  16  command word
- recording  out  1  take active
- song_done  out  1  one-cycle pulse when the end marker has been written
- length  out  INDEX_W  data entries written this take, excluding the end marker
- full  out  1  index has reached the last slot (2^INDEX_W-1)
- dropped  out  1  sticky per take: a note event was discarded

Behaviour:
- Command word format:
  - Note: bit15=0, [14:9]=note, [8:3]=duration, [2:0]=0.
  - WAIT: bit15=1, [14:9]=beats, [8:3]=0, [2:0]=0.
  - End marker: 16'h0000.
- WAIT(n) encodes n beats. WAIT(0) is never written.
- wr_en, wr_addr and wr_data are registered. A write triggered by inputs sampled at edge N is presented for the cycle after edge N. wr_en is high for exactly one cycle per entry.
- Reset: all outputs 0, state S_IDLE, index 0, beat_cnt 0.
- States and transitions:
  - S_IDLE: when record=1, latch song, clear index, beat_cnt, length and dropped; go to S_REC.
  - S_REC:
    - beat: beat_cnt+1. If beat_cnt==MAX_WAIT when the beat arrives, write WAIT(MAX_WAIT) and set beat_cnt=1.
    - note_valid with note==0 && duration==0: ignored, not counted as dropped.
    - Valid note with beat_cnt==0: write the note.
    - Valid note with beat_cnt>0: write WAIT(beat_cnt), hold the note in a pending register, clear beat_cnt, go to S_NOTE.
    - record=0: go to S_FLUSH.
  - S_NOTE: write the pending note, return to S_REC. A note_valid arriving here is discarded and sets dropped. A beat arriving here is counted.
  - S_FLUSH: if beat_cnt>0, write WAIT(beat_cnt). Go to S_END.
  - S_END: write 16'h0000 at the current index. Go to S_DONE.
  - S_DONE: song_done=1 for one cycle, then S_IDLE. A new take requires record=1 in S_IDLE.
- Index increments after every data write. length = index after the final data write.
- Simultaneous events:
  - beat and note_valid in the same cycle: the beat is counted first and included in the preceding WAIT.
  - beat and record falling in the same cycle: the beat is counted and flushed.
  - WAIT(MAX_WAIT) overflow and note_valid in the same cycle: the wait is written first, the note goes to pending, go to S_NOTE.
- Full: when index reaches 2^INDEX_W-1 after a data write, full=1 and the block goes to S_END regardless of record. Any pending note is discarded and sets dropped. Notes and beats after full are ignored.
- recording=1 in S_REC, S_NOTE, S_FLUSH and S_END.
- length, full and dropped hold after a take until the next take starts.
- Reset mid-take: immediate return to S_IDLE. No end marker is written; the partial song is undefined for playback.

Optional Feature:
- SKIP_LEAD_SILENCE_EN defined: beat_cnt stays 0 until the first accepted note of the take. Leading silence is not recorded.
- Not defined: beats are counted from entry to S_REC, so leading silence produces a leading WAIT.

Test Plan:
- Slot 1, record=1, no beats, note=20/duration=8 → wr_addr=0x080, data 0x2840. Then record=0 → 0x0000 at 0x081, song_done pulse, length=1.
- record=1, 3 beats, note=5/duration=4 → 0x8600 at idx0, then 0x0A20 at idx1 on the following write cycle. recording=1 throughout.
- record=1, 70 beats, record=0 → 0xFE00 at idx0, 0x8E00 at idx1, 0x0000 at idx2, length=2. With SKIP_LEAD_SILENCE_EN: only 0x0000 at idx0, length=0.
- 2 beats, then note_valid on two consecutive cycles → WAIT 0x8400, first note written, second discarded, dropped=1.
- 127 notes with no beats → entries at idx0..126, 0x0000 at idx127, full=1, song_done without record falling. A 128th note produces no write.
- Assert reset during S_NOTE → next cycle wr_en=0, recording=0, all outputs 0. Record restarts from idx0.
